// File: rtl/posit_add_arbiter.sv
// Round-robin front end for a shared posit add core: two requesters, zero/NaR
// bypass, and a watchdog that turns a hung core operation into an error result.
module posit_add_arbiter #(
    parameter int N       = 8,
    parameter int ES      = 3,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [N-1:0] resp_data,
    output logic         resp_err,
    output logic         core_start,
    output logic [N-1:0] core_a,
    output logic [N-1:0] core_b,
    input  logic         core_done,
    input  logic [N-1:0] core_result,
    output logic [1:0]   dbg_state
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
    localparam logic [N-1:0]  NAR       = {1'b1, {(N-1){1'b0}}};

    if (TIMEOUT < 2 || ES < 0) begin : g_param_check
        $error("posit_add_arbiter: TIMEOUT must be >= 2 and ES >= 0");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q;
    logic            owner_q;
    logic            last_grant_q;
    logic [WW-1:0]   wdog_q;
    logic [1:0]      resp_valid_q;
    logic [N-1:0]    resp_data_q;
    logic            resp_err_q;
    logic            core_start_q;
    logic [N-1:0]    core_a_q;
    logic [N-1:0]    core_b_q;

    logic            grant_d;
    logic            accept_d;
    logic [1:0]      grant_oh_d;
    logic [1:0]      owner_oh_d;
    logic [N-1:0]    sel_a_d;
    logic [N-1:0]    sel_b_d;

    // Handshakes are valid/ready: a transfer happens on a rising edge where both
    // valid and ready are high. Requesters hold operands until req_ready; the
    // response is held until resp_ready of its owner, other ready bits ignored.
    always_comb begin
        grant_d = 1'b0;
        if (req_valid == 2'b11) begin
            grant_d = ~last_grant_q;
        end else if (req_valid[1]) begin
            grant_d = 1'b1;
        end
    end

    assign accept_d   = (state_q == S_IDLE) && (req_valid != 2'b00) && !reset;
    assign grant_oh_d = grant_d ? 2'b10 : 2'b01;
    assign owner_oh_d = owner_q ? 2'b10 : 2'b01;
    assign sel_a_d    = grant_d ? req1_a : req0_a;
    assign sel_b_d    = grant_d ? req1_b : req0_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wdog_q       <= '0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        owner_q <= grant_d;
                        // NaR dominates, then an exact zero on either side passes the other through.
                        if (sel_a_d == NAR || sel_b_d == NAR) begin
                            resp_data_q  <= NAR;
                            resp_err_q   <= 1'b0;
                            resp_valid_q <= grant_oh_d;
                            state_q      <= S_RESP;
                        end else if (sel_a_d == '0) begin
                            resp_data_q  <= sel_b_d;
                            resp_err_q   <= 1'b0;
                            resp_valid_q <= grant_oh_d;
                            state_q      <= S_RESP;
                        end else if (sel_b_d == '0) begin
                            resp_data_q  <= sel_a_d;
                            resp_err_q   <= 1'b0;
                            resp_valid_q <= grant_oh_d;
                            state_q      <= S_RESP;
                        end else begin
                            core_start_q <= 1'b1;
                            core_a_q     <= sel_a_d;
                            core_b_q     <= sel_b_d;
                            state_q      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    core_start_q <= 1'b0;
                    wdog_q       <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        resp_data_q  <= core_result;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= owner_oh_d;
                        state_q      <= S_RESP;
                    end else if (wdog_q == WDOG_LAST) begin
                        resp_data_q  <= NAR;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= owner_oh_d;
                        state_q      <= S_RESP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid_q <= 2'b00;
                        last_grant_q <= owner_q;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = accept_d ? grant_oh_d : 2'b00;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign core_start = core_start_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Directed bench for posit_add_arbiter: inputs change on the falling edge and
// outputs are checked 1 ns later, against hand-computed expectations.
module tb_posit_add_arbiter;

    localparam int N       = 8;
    localparam int ES      = 3;
    localparam int TIMEOUT = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [7:0] BP_WHO [5] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
    localparam logic [7:0] BP_A   [5] = '{8'h00, 8'h80, 8'h33, 8'h00, 8'h00};
    localparam logic [7:0] BP_B   [5] = '{8'h5C, 8'h40, 8'h00, 8'h80, 8'h00};
    localparam logic [7:0] BP_EXP [5] = '{8'h5C, 8'h80, 8'h33, 8'h80, 8'h00};

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [N-1:0] resp_data;
    logic         resp_err;
    logic         core_start;
    logic [N-1:0] core_a, core_b;
    logic         core_done;
    logic [N-1:0] core_result;
    logic [1:0]   dbg_state;

    int n_vec     = 0;
    int n_err     = 0;
    int start_cnt = 0;
    logic [N-1:0] exp_q[$];

    posit_add_arbiter #(.N(N), .ES(ES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_start === 1'b1) start_cnt++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_quiet();
        req_valid   = 2'b00;
        resp_ready  = 2'b00;
        core_done   = 1'b0;
        core_result = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive_quiet();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
        n_vec++; if (resp_data !== 8'h00 || resp_err !== 1'b0) begin n_err++; $display("FAIL reset_resp: got data %h err %b want 00/0", resp_data, resp_err); end
        n_vec++; if (core_start !== 1'b0 || core_a !== 8'h00 || core_b !== 8'h00) begin n_err++; $display("FAIL reset_core: got start %b a %h b %h want 0/00/00", core_start, core_a, core_b); end
        n_vec++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    endtask

    task automatic test_core_op();
        int s0;
        s0 = start_cnt;
        step(); req_valid = 2'b01; req0_a = 8'h40; req0_b = 8'h40; #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL core_req_ready: got %b want 01", req_ready); end
        step(); req_valid = 2'b00; #1;
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL core_req_ready_drop: got %b want 00", req_ready); end
        n_vec++; if (core_start !== 1'b1 || core_a !== 8'h40 || core_b !== 8'h40) begin n_err++; $display("FAIL core_issue: got start %b a %h b %h want 1/40/40", core_start, core_a, core_b); end
        step(); #1;
        n_vec++; if (core_start !== 1'b0 || dbg_state !== S_WAIT) begin n_err++; $display("FAIL core_wait: got start %b state %0d want 0/%0d", core_start, dbg_state, S_WAIT); end
        step();
        step(); core_done = 1'b1; core_result = 8'h48; #1;
        n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL core_early_resp: got %b want 00", resp_valid); end
        step(); core_done = 1'b0; core_result = 8'h00; #1;
        n_vec++; if (resp_valid !== 2'b01 || resp_data !== 8'h48 || resp_err !== 1'b0) begin n_err++; $display("FAIL core_resp: got valid %b data %h err %b want 01/48/0", resp_valid, resp_data, resp_err); end
        resp_ready = 2'b01;
        step(); resp_ready = 2'b00; #1;
        n_vec++; if (resp_valid !== 2'b00 || dbg_state !== S_IDLE) begin n_err++; $display("FAIL core_done_idle: got valid %b state %0d want 00/%0d", resp_valid, dbg_state, S_IDLE); end
        n_vec++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL core_start_pulses: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_round_robin();
        logic       g;
        logic [1:0] oh;
        logic [N-1:0] exp;
        apply_reset();
        req0_a = 8'h40; req0_b = 8'h40; req1_a = 8'h50; req1_b = 8'h30;
        for (int op = 0; op < 4; op++) begin
            g  = op[0];
            oh = g ? 2'b10 : 2'b01;
            step(); req_valid = 2'b11; resp_ready = 2'b00; #1;
            n_vec++; if (req_ready !== oh) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", op, req_ready, oh); end
            step(); #1;
            n_vec++; if (core_start !== 1'b1 || core_a !== (g ? 8'h50 : 8'h40) || core_b !== (g ? 8'h30 : 8'h40)) begin
                n_err++; $display("FAIL rr_issue%0d: got start %b a %h b %h for requester %0d", op, core_start, core_a, core_b, g);
            end
            exp_q.push_back(8'h60 + 8'(op));
            step(); core_done = 1'b1; core_result = 8'h60 + 8'(op); #1;
            step(); core_done = 1'b0; #1;
            exp = exp_q.pop_front();
            n_vec++; if (resp_valid !== oh || resp_data !== exp || req_ready !== 2'b00) begin
                n_err++; $display("FAIL rr_resp%0d: got valid %b data %h ready %b want %b/%h/00", op, resp_valid, resp_data, req_ready, oh, exp);
            end
            resp_ready = 2'b11;
        end
        step(); req_valid = 2'b00; resp_ready = 2'b00;
    endtask

    task automatic test_bypass();
        int s0;
        logic [1:0] oh;
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) begin
            oh = BP_WHO[i][0] ? 2'b10 : 2'b01;
            step();
            req_valid = oh;
            if (BP_WHO[i][0]) begin req1_a = BP_A[i]; req1_b = BP_B[i]; end
            else begin req0_a = BP_A[i]; req0_b = BP_B[i]; end
            #1;
            n_vec++; if (req_ready !== oh) begin n_err++; $display("FAIL bypass_ready%0d: got %b want %b", i, req_ready, oh); end
            step(); req_valid = 2'b00; #1;
            n_vec++; if (resp_valid !== oh || resp_data !== BP_EXP[i] || resp_err !== 1'b0) begin
                n_err++; $display("FAIL bypass_resp%0d: got valid %b data %h err %b want %b/%h/0", i, resp_valid, resp_data, resp_err, oh, BP_EXP[i]);
            end
            resp_ready = oh;
            step(); resp_ready = 2'b00;
        end
        n_vec++; if (start_cnt !== s0) begin n_err++; $display("FAIL bypass_no_start: got %0d pulses want 0", start_cnt - s0); end
    endtask

    task automatic test_watchdog();
        int early;
        for (int pass = 0; pass < 2; pass++) begin
            early = 0;
            step(); req_valid = 2'b01; req0_a = 8'h40; req0_b = 8'h48; #1;
            step(); req_valid = 2'b00; #1;
            n_vec++; if (core_start !== 1'b1) begin n_err++; $display("FAIL wdog_issue%0d: got %b want 1", pass, core_start); end
            for (int i = 0; i < TIMEOUT; i++) begin
                step();
                if (pass == 1 && i == TIMEOUT - 1) begin core_done = 1'b1; core_result = 8'h5A; end
                #1;
                if (resp_valid !== 2'b00) early++;
            end
            n_vec++; if (early != 0) begin n_err++; $display("FAIL wdog_early%0d: got %0d early cycles want 0", pass, early); end
            step(); core_done = 1'b0; #1;
            if (pass == 0) begin
                n_vec++; if (resp_valid !== 2'b01 || resp_data !== 8'h80 || resp_err !== 1'b1) begin
                    n_err++; $display("FAIL wdog_abort: got valid %b data %h err %b want 01/80/1", resp_valid, resp_data, resp_err);
                end
            end else begin
                n_vec++; if (resp_valid !== 2'b01 || resp_data !== 8'h5A || resp_err !== 1'b0) begin
                    n_err++; $display("FAIL wdog_last_done: got valid %b data %h err %b want 01/5a/0", resp_valid, resp_data, resp_err);
                end
            end
            resp_ready = 2'b01;
            step(); resp_ready = 2'b00;
        end
    endtask

    task automatic test_stall();
        step(); req_valid = 2'b10; req1_a = 8'h00; req1_b = 8'h22; #1;
        n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL stall_ready: got %b want 10", req_ready); end
        step(); req_valid = 2'b11; req0_a = 8'h40; req0_b = 8'h40; resp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            #1;
            n_vec++; if (resp_valid !== 2'b10 || resp_data !== 8'h22 || resp_err !== 1'b0 || req_ready !== 2'b00) begin
                n_err++; $display("FAIL stall_hold%0d: got valid %b data %h err %b ready %b want 10/22/0/00", i, resp_valid, resp_data, resp_err, req_ready);
            end
        end
        step(); resp_ready = 2'b10;
        step(); resp_ready = 2'b00; #1;
        n_vec++; if (resp_valid !== 2'b00 || req_ready !== 2'b01) begin
            n_err++; $display("FAIL stall_release: got valid %b ready %b want 00/01", resp_valid, req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid_op();
        int bad;
        bad = 0;
        step(); req_valid = 2'b01; req0_a = 8'h40; req0_b = 8'h40; #1;
        step(); req_valid = 2'b00;
        step();
        step(); #1;
        n_vec++; if (dbg_state !== S_WAIT) begin n_err++; $display("FAIL midrst_in_wait: got %0d want %0d", dbg_state, S_WAIT); end
        reset = 1'b1; #1;
        n_vec++; if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_data !== 8'h00 || resp_err !== 1'b0) begin
            n_err++; $display("FAIL midrst_resp: got ready %b valid %b data %h err %b want 00/00/00/0", req_ready, resp_valid, resp_data, resp_err);
        end
        n_vec++; if (core_start !== 1'b0 || core_a !== 8'h00 || core_b !== 8'h00 || dbg_state !== S_IDLE) begin
            n_err++; $display("FAIL midrst_core: got start %b a %h b %h state %0d want 0/00/00/%0d", core_start, core_a, core_b, dbg_state, S_IDLE);
        end
        step(); reset = 1'b0;
        step(); core_done = 1'b1; core_result = 8'h77;
        step(); core_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            if (resp_valid !== 2'b00 || dbg_state !== S_IDLE || resp_data !== 8'h00) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL midrst_stray_done: got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_core_op();
        test_round_robin();
        test_bypass();
        test_watchdog();
        test_stall();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
